// File: rtl/ex_mem_buffer_pkg.sv
// rtl/ex_mem_buffer_pkg.sv - shared widths, occupancy states and entry type for ex_mem_buffer
package ex_mem_buffer_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RD_W_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] result;
        logic                cout;
        flags_t              flags;
        logic [RD_W_DEF-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [XLEN_DEF-1:0] store_data;
    } entry_t;

endpackage

// File: rtl/ex_flag_gen.sv
// rtl/ex_flag_gen.sv - combinational zero/negative/signed-overflow flags for the add/sub result
module ex_flag_gen #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] result,
    input  logic            a_msb,
    input  logic            b_msb,
    input  logic            sub,
    output logic            zero,
    output logic            neg,
    output logic            ovf
);

    assign zero = (result == '0);
    assign neg  = result[XLEN-1];
    // Effective b sign is inverted for subtract; overflow when both effective
    // operand signs agree but the sum sign differs from them.
    assign ovf  = (a_msb == (b_msb ^ sub)) && (result[XLEN-1] != a_msb);

endmodule

// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - 2-entry EX/MEM skid buffer; flags enabled by macro EX_FLAGS_EN
module ex_mem_buffer
    import ex_mem_buffer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_cout,
    input  logic [3:0]      alu_control_signal,
    input  logic            a_msb,
    input  logic            b_msb,
    input  logic [RD_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_cout,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_zero,
    output logic            out_neg,
    output logic            out_ovf
);

    // The entry type is sized by the package defaults.
    if (XLEN != XLEN_DEF || RD_W != RD_W_DEF) begin : g_width_check
        $error("ex_mem_buffer: XLEN/RD_W must match ex_mem_buffer_pkg defaults");
    end

    occ_t   state_q;
    occ_t   state_d;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    flags_t in_flags;
    logic   accept;
    logic   xfer;
    logic   load_main;
    logic   load_skid;
    logic   main_from_skid;

`ifdef EX_FLAGS_EN
    logic flag_zero;
    logic flag_neg;
    logic flag_ovf;
    logic unused_ctrl;

    ex_flag_gen #(.XLEN(XLEN)) u_flag_gen (
        .result (alu_result),
        .a_msb  (a_msb),
        .b_msb  (b_msb),
        .sub    (alu_control_signal[3]),
        .zero   (flag_zero),
        .neg    (flag_neg),
        .ovf    (flag_ovf)
    );

    assign in_flags    = '{zero: flag_zero, neg: flag_neg, ovf: flag_ovf};
    assign out_zero    = main_q.flags.zero;
    assign out_neg     = main_q.flags.neg;
    assign out_ovf     = main_q.flags.ovf;
    assign unused_ctrl = ^alu_control_signal[2:0];
`else
    logic unused_flag_inputs;

    // Flag fields are written constant zero and never read, so they reduce away.
    assign in_flags           = '0;
    assign out_zero           = 1'b0;
    assign out_neg            = 1'b0;
    assign out_ovf            = 1'b0;
    assign unused_flag_inputs = ^{alu_control_signal, a_msb, b_msb, main_q.flags, skid_q.flags};
`endif

    assign in_entry = '{
        result:     alu_result,
        cout:       alu_cout,
        flags:      in_flags,
        rd:         rd,
        reg_write:  reg_write,
        mem_read:   mem_read,
        mem_write:  mem_write,
        store_data: store_data
    };

    // Handshake signals come from registered state only.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign xfer      = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and which register captures what; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !xfer) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (!accept && xfer) begin
                        state_d = EMPTY;
                    end else if (accept && xfer) begin
                        load_main = 1'b1;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_d        = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Entry storage: main feeds the outputs, skid holds the overflow entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_entry;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_result     = main_q.result;
    assign out_cout       = main_q.cout;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_read   = main_q.mem_read;
    assign out_mem_write  = main_q.mem_write;
    assign out_store_data = main_q.store_data;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - scoreboard bench for ex_mem_buffer against a queue reference model
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] alu_result = '0;
    logic        alu_cout = 1'b0;
    logic [3:0]  alu_control_signal = '0;
    logic        a_msb = 1'b0;
    logic        b_msb = 1'b0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] store_data = '0;
    logic [63:0] out_result;
    logic        out_cout;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [63:0] out_store_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;

    typedef struct packed {
        logic [63:0] result;
        logic        cout;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] sd;
        logic        zero;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] cur_flags = 3'b000;
    int         n_vec = 0;
    int         n_bad = 0;
    int         n_now;
    logic [1:0] f2_exp;

    ex_mem_buffer #(.XLEN(64), .RD_W(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .alu_result         (alu_result),
        .alu_cout           (alu_cout),
        .alu_control_signal (alu_control_signal),
        .a_msb              (a_msb),
        .b_msb              (b_msb),
        .rd                 (rd),
        .reg_write          (reg_write),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .store_data         (store_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_result         (out_result),
        .out_cout           (out_cout),
        .out_rd             (out_rd),
        .out_reg_write      (out_reg_write),
        .out_mem_read       (out_mem_read),
        .out_mem_write      (out_mem_write),
        .out_store_data     (out_store_data),
        .out_zero           (out_zero),
        .out_neg            (out_neg),
        .out_ovf            (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e = '{result: alu_result, cout: alu_cout, rd: rd, rw: reg_write, mr: mem_read,
              mw: mem_write, sd: store_data, zero: cur_flags[2], neg: cur_flags[1], ovf: cur_flags[0]};
        return e;
    endfunction

    function automatic exp_t dut_entry();
        exp_t e;
        e = '{result: out_result, cout: out_cout, rd: out_rd, rw: out_reg_write, mr: out_mem_read,
              mw: out_mem_write, sd: out_store_data, zero: out_zero, neg: out_neg, ovf: out_ovf};
        return e;
    endfunction

    // Drive one add/sub operation from real operands; flags from signed arithmetic.
    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        logic [64:0]        u;
        logic signed [64:0] s;
        if (c[3]) begin
            u = {1'b0, a} + {1'b0, ~b} + 65'd1;
            s = $signed({a[63], a}) - $signed({b[63], b});
        end else begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[63], a}) + $signed({b[63], b});
        end
        alu_control_signal = c;
        a_msb      = a[63];
        b_msb      = b[63];
        alu_result = u[63:0];
        alu_cout   = u[64];
`ifdef EX_FLAGS_EN
        cur_flags  = {s[63:0] == 64'd0, s[63], s[64] != s[63]};
`else
        cur_flags  = 3'b000;
`endif
        rd         = 5'($urandom);
        reg_write  = 1'($urandom);
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        store_data = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two entries.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            n_now = exp_q.size();
            if (out_ready && n_now > 0) begin
                void'(exp_q.pop_front());
            end
            if (in_valid && n_now < 2) begin
                exp_q.push_back(cur_exp());
            end
        end
    end

    // Monitor: compare handshake and presented entry against the model.
    always @(negedge clk) begin
        check("out_valid", 160'(out_valid), 160'(exp_q.size() > 0));
        check("in_ready", 160'(in_ready), 160'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check("entry", 160'(dut_entry()), 160'(exp_q[0]));
        end
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 160'(out_valid), 160'(1'b0));
        check("reset in_ready", 160'(in_ready), 160'(1'b1));
        check("reset outputs", 160'(dut_entry()), 160'(0));
        reset = 1'b0;

        // Single entry latency.
        set_op(64'h5, 64'h0, 4'b0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("latency out_valid", 160'(out_valid), 160'(1'b1));
        check("latency result", 160'(out_result), 160'(64'h5));
        check("latency zero", 160'(out_zero), 160'(1'b0));
        step();

        // Fill to TWO, then drain in order.
        out_ready = 1'b0;
        set_op(64'hA, 64'h0, 4'b0000);
        in_valid = 1'b1;
        step();
        set_op(64'hB, 64'h0, 4'b0000);
        step();
        in_valid = 1'b0;
        check("full in_ready", 160'(in_ready), 160'(1'b0));
        check("full head", 160'(out_result), 160'(64'hA));
        out_ready = 1'b1;
        step();
        check("drain second", 160'(out_result), 160'(64'hB));
        check("drain second valid", 160'(out_valid), 160'(1'b1));
        step();
        check("drained", 160'(out_valid), 160'(1'b0));

        // Subtract overflow into the sign bit.
        set_op(64'h0, 64'h8000_0000_0000_0000, 4'b1000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef EX_FLAGS_EN
        f2_exp = 2'b11;
`else
        f2_exp = 2'b00;
`endif
        check("sub neg/ovf", 160'({out_neg, out_ovf}), 160'(f2_exp));
        step();

        // Zero result from an add.
        set_op(64'h0, 64'h0, 4'b0100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef EX_FLAGS_EN
        f2_exp = 2'b10;
`else
        f2_exp = 2'b00;
`endif
        check("add zero/ovf", 160'({out_zero, out_ovf}), 160'(f2_exp));
        step();

        // Flush while full with a competing input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
        step();
        set_op({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
        step();
        flush = 1'b1;
        set_op({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 160'(out_valid), 160'(1'b0));
        check("flush in_ready", 160'(in_ready), 160'(1'b1));
        step();
        check("flush not captured", 160'(out_valid), 160'(1'b0));

        // Asynchronous reset while full.
        in_valid = 1'b1;
        set_op({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
        step();
        step();
        in_valid = 1'b0;
        check("pre-reset full", 160'(in_ready), 160'(1'b0));
        #2;
        reset = 1'b1;
        #1;
        check("async reset out_valid", 160'(out_valid), 160'(1'b0));
        check("async reset in_ready", 160'(in_ready), 160'(1'b1));
        step();
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       set_op(a, a, 4'b1000);
                1:       set_op(64'h7FFF_FFFF_FFFF_FFFF, {32'h0, $urandom}, 4'b0000);
                2:       set_op({1'b1, a[62:0]}, {1'b0, b[62:0]}, 4'b1000);
                default: set_op(a, b, 4'($urandom));
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("final empty", 160'(out_valid), 160'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
